traffic_light_sequencer: RTL and testbench

TRAFFIC_LIGHT_SEQUENCER -- requirements
Module: traffic_light_sequencer

---
 rtl/traffic_light_sequencer_pkg.sv | 39 +++
 rtl/traffic_light_sequencer_tick.sv | 25 ++
 rtl/traffic_light_sequencer.sv | 128 ++++++++++++
 tb/tb_traffic_light_sequencer.sv | 215 +++++++++++++++++++++
 4 files changed

// File: rtl/traffic_light_sequencer_pkg.sv
// rtl/traffic_light_sequencer_pkg.sv - shared states, direction indices and default timing
// for the traffic light sequencer.
package traffic_light_sequencer_pkg;

  typedef enum logic [1:0] {
    S_TO_NS    = 2'd0,
    S_NS_GREEN = 2'd1,
    S_TO_EW    = 2'd2,
    S_EW_GREEN = 2'd3
  } tls_state_e;

  localparam int DIR_N = 0;
  localparam int DIR_E = 1;
  localparam int DIR_S = 2;
  localparam int DIR_W = 3;

  localparam int DEF_MIN_GREEN   = 4;
  localparam int DEF_MAX_GREEN   = 12;
  localparam int DEF_CLEAR_TICKS = 2;

  // Lamp pattern, indexed by direction, that a state shows.
  function automatic logic [3:0] green_mask(input tls_state_e s);
    logic [3:0] m;
    m = '0;
    case (s)
      S_NS_GREEN: begin
        m[DIR_N] = 1'b1;
        m[DIR_S] = 1'b1;
      end
      S_EW_GREEN: begin
        m[DIR_E] = 1'b1;
        m[DIR_W] = 1'b1;
      end
      default: m = '0;
    endcase
    return m;
  endfunction

endpackage

// File: rtl/traffic_light_sequencer_tick.sv
// rtl/traffic_light_sequencer_tick.sv - tick_edge_detect: samples the slow animation clock
// as data and emits a registered one-cycle pulse per rising edge.
module tick_edge_detect (
  input  logic dclk,
  input  logic clr,
  input  logic din,
  output logic tick
);

  logic din_q;
  logic din_qq;

  always_ff @(posedge dclk) begin
    if (clr) begin
      din_q  <= 1'b0;
      din_qq <= 1'b0;
      tick   <= 1'b0;
    end else begin
      din_q  <= din;
      din_qq <= din_q;
      tick   <= din_q & ~din_qq;
    end
  end

endmodule

// File: rtl/traffic_light_sequencer.sv
// rtl/traffic_light_sequencer.sv - two-axis traffic light FSM with demand-driven early switch.
// Optional TLS_GAME_OVER_FREEZE_EN: game_over blanks all lamps and freezes the sequencer.
module traffic_light_sequencer
  import traffic_light_sequencer_pkg::*;
#(
  parameter int MIN_GREEN   = DEF_MIN_GREEN,
  parameter int MAX_GREEN   = DEF_MAX_GREEN,
  parameter int CLEAR_TICKS = DEF_CLEAR_TICKS
) (
  input  logic       dclk,
  input  logic       clr,
  input  logic       animateClk,
  input  logic [3:0] req,
  input  logic       game_over,
  output logic       traffic0_color,
  output logic       traffic1_color,
  output logic       traffic2_color,
  output logic       traffic3_color,
  output logic [1:0] phase
);

  localparam logic [7:0] MIN_LAST   = 8'(MIN_GREEN - 1);
  localparam logic [7:0] MAX_LAST   = 8'(MAX_GREEN - 1);
  localparam logic [7:0] CLEAR_LAST = 8'(CLEAR_TICKS - 1);

  logic       tick;
  tls_state_e state;
  logic [7:0] cnt;
  logic       pend_ns;
  logic       pend_ew;
  logic [3:0] color;
  logic       ns_req;
  logic       ew_req;
  logic       ns_done;
  logic       ew_done;
  logic       freeze;

  tick_edge_detect u_tick (
    .dclk (dclk),
    .clr  (clr),
    .din  (animateClk),
    .tick (tick)
  );

`ifdef TLS_GAME_OVER_FREEZE_EN
  assign freeze = game_over;
`else
  logic unused_game_over;
  assign unused_game_over = game_over;
  assign freeze           = 1'b0;
`endif

  assign ns_req  = req[DIR_N] | req[DIR_S];
  assign ew_req  = req[DIR_E] | req[DIR_W];
  // A green ends at its cap, or early once the minimum is served and the cross axis waits.
  assign ns_done = (cnt == MAX_LAST) || ((cnt >= MIN_LAST) && pend_ew);
  assign ew_done = (cnt == MAX_LAST) || ((cnt >= MIN_LAST) && pend_ns);

  always_ff @(posedge dclk) begin
    if (clr) begin
      state   <= S_TO_NS;
      cnt     <= 8'd0;
      pend_ns <= 1'b0;
      pend_ew <= 1'b0;
      color   <= 4'b0000;
    end else if (freeze) begin
      color <= 4'b0000;
    end else begin
      pend_ns <= pend_ns | ns_req;
      pend_ew <= pend_ew | ew_req;
      color   <= green_mask(state);
      if (tick) begin
        case (state)
          S_TO_NS: begin
            if (cnt == CLEAR_LAST) begin
              state   <= S_NS_GREEN;
              cnt     <= 8'd0;
              pend_ns <= 1'b0;
              color   <= green_mask(S_NS_GREEN);
            end else begin
              cnt <= cnt + 8'd1;
            end
          end
          S_NS_GREEN: begin
            if (ns_done) begin
              state <= S_TO_EW;
              cnt   <= 8'd0;
              color <= 4'b0000;
            end else begin
              cnt <= cnt + 8'd1;
            end
          end
          S_TO_EW: begin
            if (cnt == CLEAR_LAST) begin
              state   <= S_EW_GREEN;
              cnt     <= 8'd0;
              pend_ew <= 1'b0;
              color   <= green_mask(S_EW_GREEN);
            end else begin
              cnt <= cnt + 8'd1;
            end
          end
          S_EW_GREEN: begin
            if (ew_done) begin
              state <= S_TO_NS;
              cnt   <= 8'd0;
              color <= 4'b0000;
            end else begin
              cnt <= cnt + 8'd1;
            end
          end
          default: begin
            state <= S_TO_NS;
            cnt   <= 8'd0;
            color <= 4'b0000;
          end
        endcase
      end
    end
  end

  assign phase          = state;
  assign traffic0_color = color[DIR_N];
  assign traffic1_color = color[DIR_E];
  assign traffic2_color = color[DIR_S];
  assign traffic3_color = color[DIR_W];

endmodule

// File: tb/tb_traffic_light_sequencer.sv
// tb/tb_traffic_light_sequencer.sv - self-checking bench for traffic_light_sequencer.
module tb_traffic_light_sequencer;

  localparam int MIN_G = 4;
  localparam int MAX_G = 12;
  localparam int CLR_T = 2;

  logic       dclk = 1'b0;
  logic       clr = 1'b1;
  logic       animateClk = 1'b0;
  logic [3:0] req = 4'b0000;
  logic       game_over = 1'b0;
  logic       t0, t1, t2, t3;
  logic [1:0] phase;
  logic [3:0] col;

  int checks = 0;
  int errors = 0;

  // Reference: phase 0..3 cycles in order; elapsed counts ticks spent in the current phase.
  int m_phase = 0;
  int m_elapsed = 0;
  bit m_pns = 0;
  bit m_pew = 0;
  bit exp_freeze = 0;

  traffic_light_sequencer #(
    .MIN_GREEN   (MIN_G),
    .MAX_GREEN   (MAX_G),
    .CLEAR_TICKS (CLR_T)
  ) dut (
    .dclk           (dclk),
    .clr            (clr),
    .animateClk     (animateClk),
    .req            (req),
    .game_over      (game_over),
    .traffic0_color (t0),
    .traffic1_color (t1),
    .traffic2_color (t2),
    .traffic3_color (t3),
    .phase          (phase)
  );

  assign col = {t3, t2, t1, t0};

  always #5 dclk = ~dclk;

  task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp_v);
    checks++;
    assert (obs === exp_v) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp_v);
    end
  endtask

  function automatic logic [3:0] exp_col();
    if (exp_freeze) return 4'b0000;
    if (m_phase == 1) return 4'b0101;
    if (m_phase == 3) return 4'b1010;
    return 4'b0000;
  endfunction

  task automatic check_outputs(input string tag);
    check({tag, "_phase"}, 8'(phase), 8'(m_phase));
    check({tag, "_color"}, 8'(col), 8'(exp_col()));
  endtask

  task automatic model_reset();
    m_phase = 0;
    m_elapsed = 0;
    m_pns = 0;
    m_pew = 0;
  endtask

  // r: requests held before the tick takes effect; re2: requests on the tick edge itself.
  task automatic model_tick(input logic [3:0] r, input logic [3:0] re2);
    bit ent_ns, ent_ew;
    if (exp_freeze) return;
    m_pns |= r[0] | r[2];
    m_pew |= r[1] | r[3];
    ent_ns = 0;
    ent_ew = 0;
    m_elapsed++;
    case (m_phase)
      0: if (m_elapsed == CLR_T) begin m_phase = 1; m_elapsed = 0; ent_ns = 1; end
      1: if (m_elapsed == MAX_G || (m_elapsed >= MIN_G && m_pew)) begin m_phase = 2; m_elapsed = 0; end
      2: if (m_elapsed == CLR_T) begin m_phase = 3; m_elapsed = 0; ent_ew = 1; end
      default: if (m_elapsed == MAX_G || (m_elapsed >= MIN_G && m_pns)) begin m_phase = 0; m_elapsed = 0; end
    endcase
    m_pns |= re2[0] | re2[2];
    m_pew |= re2[1] | re2[3];
    if (ent_ns) m_pns = 0;
    if (ent_ew) m_pew = 0;
  endtask

  // Called at a falling edge; returns at the falling edge after the tick has taken effect.
  task automatic tick_step(input logic [3:0] r, input logic [3:0] re2);
    logic [7:0] p0, c0;
    p0 = 8'(m_phase);
    c0 = 8'(exp_col());
    req = r;
    animateClk = 1'b1;
    @(negedge dclk);
    @(negedge dclk);
    check("latency_phase", 8'(phase), p0);
    check("latency_color", 8'(col), c0);
    req = re2;
    animateClk = 1'b0;
    @(negedge dclk);
    req = 4'b0000;
    model_tick(r, re2);
    check_outputs("tick");
  endtask

  task automatic idle(input int n, input logic [3:0] r);
    for (int i = 0; i < n; i++) begin
      req = r;
      @(negedge dclk);
      if (!exp_freeze) begin
        m_pns |= r[0] | r[2];
        m_pew |= r[1] | r[3];
      end
    end
    req = 4'b0000;
  endtask

  always @(negedge dclk) begin
    if (!clr) check("axis_exclusive", 8'((col[0] | col[2]) & (col[1] | col[3])), 8'd0);
  end

  initial begin
    #1000000;
    $display("FAIL watchdog_timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end

  initial begin
    logic [3:0] r, re2;
    repeat (3) @(negedge dclk);
    check_outputs("reset");
    clr = 1'b0;
    @(negedge dclk);
    check_outputs("post_reset");

    // Two clearance ticks into NS green; an N request on the entry edge must be dropped.
    tick_step(4'b0000, 4'b0000);
    tick_step(4'b0000, 4'b0001);
    check("ns_entry_phase", 8'(phase), 8'd1);
    check("ns_entry_color", 8'(col), 8'b0101);

    for (int i = 0; i < MAX_G; i++) tick_step(4'b0000, 4'b0000);
    check("max_green_switch", 8'(phase), 8'd2);
    for (int i = 0; i < CLR_T; i++) tick_step(4'b0000, 4'b0000);
    check("ew_entry_phase", 8'(phase), 8'd3);
    // EW must run full length since the dropped N request left nothing pending.
    for (int i = 0; i < MAX_G - 1; i++) tick_step(4'b0000, 4'b0000);
    check("ew_full_length", 8'(phase), 8'd3);
    tick_step(4'b0000, 4'b0000);
    for (int i = 0; i < CLR_T; i++) tick_step(4'b0000, 4'b0000);
    check("ns_again", 8'(phase), 8'd1);

    // E request at green tick 1: early switch exactly at MIN_GREEN.
    tick_step(4'b0010, 4'b0000);
    for (int i = 1; i < MIN_G - 1; i++) tick_step(4'b0000, 4'b0000);
    check("min_not_early", 8'(phase), 8'd1);
    tick_step(4'b0000, 4'b0000);
    check("min_green_switch", 8'(phase), 8'd2);

    for (int k = 0; k < 150; k++) begin
      r   = ($urandom_range(0, 2) == 0) ? 4'($urandom_range(0, 15)) : 4'b0000;
      re2 = ($urandom_range(0, 5) == 0) ? 4'($urandom_range(0, 15)) : 4'b0000;
      tick_step(r, re2);
      idle($urandom_range(0, 2), ($urandom_range(0, 4) == 0) ? 4'($urandom_range(0, 15)) : 4'b0000);
    end

    // Game-over in the middle of an EW green.
    for (int i = 0; i < 80 && !(m_phase == 3 && m_elapsed == 2); i++) tick_step(4'b0000, 4'b0000);
    check("reach_ew_mid", 8'(phase), 8'd3);
    game_over = 1'b1;
`ifdef TLS_GAME_OVER_FREEZE_EN
    exp_freeze = 1'b1;
`endif
    @(negedge dclk);
    check_outputs("freeze_enter");
    for (int i = 0; i < 20; i++) tick_step(4'($urandom_range(0, 15)), 4'b0000);
    game_over = 1'b0;
    exp_freeze = 1'b0;
    @(negedge dclk);
    check_outputs("freeze_release");
    for (int i = 0; i < MAX_G + 2; i++) tick_step(4'b0000, 4'b0000);

    // Reset in the middle of a clearance while animateClk is rising.
    for (int i = 0; i < 40 && !(m_phase == 0 || m_phase == 2); i++) tick_step(4'b0000, 4'b0000);
    check("reach_clearance", 8'(phase[0]), 8'd0);
    req = 4'b1111;
    animateClk = 1'b1;
    @(negedge dclk);
    clr = 1'b1;
    @(negedge dclk);
    model_reset();
    check_outputs("clr_mid_clear");
    clr = 1'b0;
    animateClk = 1'b0;
    req = 4'b0000;
    @(negedge dclk);
    check_outputs("clr_no_tick");
    tick_step(4'b0000, 4'b0000);
    tick_step(4'b0000, 4'b0000);
    check("restart_ns", 8'(phase), 8'd1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
